// File: rtl/band_ctrl.sv
// -----------------------------------------------------------------------------
// band_ctrl
//   Two-band (144/430) station controller. Raw front-panel switches and the
//   operator PTT are synchronized and debounced, then drive a small FSM that
//   sequences the band mux code and keys the PTT only once the band is settled.
//   A band change always passes through a guard interval of band code 000.
//
//   States:
//     state  | meaning
//     -------+-----------------------------------------------------------
//     OFF    | station disabled, band=000, ptt released
//     GUARD  | band=000 while a newly latched target settles, busy=1
//     RX     | target band applied, receive; keys to TX when armed + PTT
//     TX     | target band applied, ptt=0; band changes only flag fault
//
// Ports
//   clk       system clock, all state on rising edge
//   reset     asynchronous active-low reset
//   sw_en     raw enable switch (1 = station on), asynchronous
//   sw_rx430  raw receive-band switch (0 = 144, 1 = 430), asynchronous
//   sw_tx430  raw transmit-band switch (0 = 144, 1 = 430), asynchronous
//   ptt_in    raw operator PTT (0 = transmit), asynchronous
//   band      registered band code to the band mux
//   ptt       registered PTT to the sequencer (0 = transmit)
//   busy      registered, 1 while in GUARD
//   fault     registered sticky flag: band switch moved while transmitting
// -----------------------------------------------------------------------------
module band_ctrl #(
   parameter int DEB_CYCLES   = 16,
   parameter int GUARD_CYCLES = 64,
   parameter int CNT_W        = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sw_en,
   input  logic       sw_rx430,
   input  logic       sw_tx430,
   input  logic       ptt_in,
   output logic [2:0] band,
   output logic       ptt,
   output logic       busy,
   output logic       fault
);

   localparam logic [1:0] S_OFF   = 2'd0;
   localparam logic [1:0] S_GUARD = 2'd1;
   localparam logic [1:0] S_RX    = 2'd2;
   localparam logic [1:0] S_TX    = 2'd3;

   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   // channel order {ptt, tx, rx, en}; the PTT path idles released (1)
   localparam logic [3:0] CH_RST = 4'b1000;

   logic [3:0] sync1;
   logic [3:0] sync2;
   logic [3:0] db;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= CH_RST;
         sync2 <= CH_RST;
      end else begin
         sync1 <= {ptt_in, sw_tx430, sw_rx430, sw_en};
         sync2 <= sync1;
      end
   end

   // Counter tracks consecutive samples that disagree with the accepted
   // level; the level flips on the DEB_CYCLES-th such sample.
   for (genvar i = 0; i < 4; i++) begin : g_deb
      logic [CNT_W-1:0] cnt;
      logic             q;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            cnt <= '0;
            q   <= CH_RST[i];
         end else if (sync2[i] == q) begin
            cnt <= '0;
         end else if (cnt >= DEB_LAST) begin
            q   <= sync2[i];
            cnt <= '0;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end
      end

      assign db[i] = q;
   end

   logic en_db;
   logic rx_db;
   logic tx_db;
   logic ptt_db;

   assign en_db  = db[0];
   assign rx_db  = db[1];
   assign tx_db  = db[2];
   assign ptt_db = db[3];

   logic [2:0] req;

   always_comb begin
      req = 3'b100;
      case ({rx_db, tx_db})
         2'b00:   req = 3'b100;
         2'b11:   req = 3'b101;
         2'b10:   req = 3'b110;
         2'b01:   req = 3'b111;
         default: req = 3'b100;
      endcase
   end

   logic [1:0]       state,  state_nxt;
   logic [2:0]       target, target_nxt;
   logic             arm,    arm_nxt;
   logic [CNT_W-1:0] gcnt,   gcnt_nxt;
   logic             fault_nxt;
   logic [2:0]       band_nxt;
   logic             ptt_nxt;
   logic             busy_nxt;

   always_comb begin
      state_nxt  = state;
      target_nxt = target;
      arm_nxt    = arm;
      gcnt_nxt   = gcnt;
      fault_nxt  = fault;

      case (state)
         S_OFF: begin
            if (en_db) begin
               target_nxt = req;
               gcnt_nxt   = '0;
               state_nxt  = S_GUARD;
            end
         end
         S_GUARD: begin
            if (!en_db) begin
               state_nxt = S_OFF;
            end else if (req != target) begin
               target_nxt = req;
               gcnt_nxt   = '0;
            end else if (gcnt >= GUARD_LAST) begin
               state_nxt = S_RX;
            end else if (gcnt != CNT_MAX) begin
               gcnt_nxt = gcnt + 1'b1;
            end
         end
         S_RX: begin
            if (!en_db) begin
               state_nxt = S_OFF;
            end else if (req != target) begin
               target_nxt = req;
               gcnt_nxt   = '0;
               state_nxt  = S_GUARD;
            end else if (arm && !ptt_db) begin
               state_nxt = S_TX;
            end else if (ptt_db) begin
               arm_nxt = 1'b1;
            end
         end
         S_TX: begin
            if (!en_db) begin
               state_nxt = S_OFF;
            end else begin
               // the band is never moved under a keyed transmitter
               if (req != target) fault_nxt = 1'b1;
               if (ptt_db) state_nxt = S_RX;
            end
         end
         default: state_nxt = S_OFF;
      endcase

      // a PTT held through GUARD must be released before it can key
      if (state_nxt == S_RX && state != S_RX) arm_nxt = 1'b0;
      if (state_nxt == S_OFF) fault_nxt = 1'b0;

      band_nxt = (state_nxt == S_RX || state_nxt == S_TX) ? target_nxt : 3'b000;
      ptt_nxt  = (state_nxt != S_TX);
      busy_nxt = (state_nxt == S_GUARD);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_OFF;
         target <= 3'b000;
         arm    <= 1'b0;
         gcnt   <= '0;
         fault  <= 1'b0;
         band   <= 3'b000;
         ptt    <= 1'b1;
         busy   <= 1'b0;
      end else begin
         state  <= state_nxt;
         target <= target_nxt;
         arm    <= arm_nxt;
         gcnt   <= gcnt_nxt;
         fault  <= fault_nxt;
         band   <= band_nxt;
         ptt    <= ptt_nxt;
         busy   <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_band_ctrl.sv
// -----------------------------------------------------------------------------
// tb_band_ctrl
//   Directed bench for band_ctrl with DEB_CYCLES=4, GUARD_CYCLES=8. Stimulus
//   pushes each expected output vector and the edge it should appear on into
//   a queue; a negedge monitor pops one entry per observed output change.
// -----------------------------------------------------------------------------
module tb_band_ctrl;

   localparam int DEB   = 4;
   localparam int GRD   = 8;
   localparam int LAT   = 2 + DEB + 1;

   logic       clk;
   logic       reset;
   logic       sw_en;
   logic       sw_rx430;
   logic       sw_tx430;
   logic       ptt_in;
   logic [2:0] band;
   logic       ptt;
   logic       busy;
   logic       fault;

   band_ctrl #(
      .DEB_CYCLES  (DEB),
      .GUARD_CYCLES(GRD),
      .CNT_W       (20)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .sw_en   (sw_en),
      .sw_rx430(sw_rx430),
      .sw_tx430(sw_tx430),
      .ptt_in  (ptt_in),
      .band    (band),
      .ptt     (ptt),
      .busy    (busy),
      .fault   (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [5:0] vec;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic mon_en = 1'b0;
   logic [5:0] prev_vec;
   logic [5:0] cur_vec;
   exp_t e;

   function automatic logic [5:0] mk(logic [2:0] b, logic p, logic bs, logic f);
      return {b, p, bs, f};
   endfunction

   task automatic push(logic [2:0] b, logic p, logic bs, logic f, int c);
      exp_t x;
      x.vec = mk(b, p, bs, f);
      x.cyc = c;
      sb.push_back(x);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      repeat (n) step();
   endtask

   task automatic chk(string name, logic [5:0] act, logic [5:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got band/ptt/busy/fault=%b, expected %b", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         cur_vec = {band, ptt, busy, fault};
         if (cur_vec !== prev_vec) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change: cycle %0d got %b, nothing expected", cyc, cur_vec);
            end else begin
               e = sb.pop_front();
               if (cur_vec !== e.vec || cyc < e.cyc - 1 || cyc > e.cyc + 1) begin
                  errors++;
                  $display("FAIL event: got %b at cycle %0d, expected %b at cycle %0d",
                           cur_vec, cyc, e.vec, e.cyc);
               end
            end
            prev_vec = cur_vec;
         end
      end
   end

   initial begin
      int t;
      reset    = 1'b0;
      sw_en    = 1'b0;
      sw_rx430 = 1'b0;
      sw_tx430 = 1'b0;
      ptt_in   = 1'b1;
      idle(3);
      chk("reset_state", {band, ptt, busy, fault}, mk(3'b000, 1'b1, 1'b0, 1'b0));
      prev_vec = mk(3'b000, 1'b1, 1'b0, 1'b0);
      reset  = 1'b1;
      mon_en = 1'b1;
      idle(2);

      // power up on 144/144: guard then band 100
      step(); t = cyc; sw_en = 1'b1;
      push(3'b000, 1'b1, 1'b1, 1'b0, t + LAT);
      push(3'b100, 1'b1, 1'b0, 1'b0, t + LAT + GRD);
      idle(20);

      // key and unkey in RX 100
      step(); t = cyc; ptt_in = 1'b0;
      push(3'b100, 1'b0, 1'b0, 1'b0, t + LAT);
      idle(12);
      step(); t = cyc; ptt_in = 1'b1;
      push(3'b100, 1'b1, 1'b0, 1'b0, t + LAT);
      idle(12);

      // move to 430/430 -> 101
      step(); t = cyc; sw_rx430 = 1'b1; sw_tx430 = 1'b1;
      push(3'b000, 1'b1, 1'b1, 1'b0, t + LAT);
      push(3'b101, 1'b1, 1'b0, 1'b0, t + LAT + GRD);
      idle(20);
      step(); t = cyc; ptt_in = 1'b0;
      push(3'b101, 0, 0, 0, t + LAT);
      idle(12);
      // band switch while transmitting: band held, fault set
      step(); t = cyc; sw_tx430 = 1'b0;
      push(3'b101, 0, 0, 1, t + LAT);
      idle(12);
      // release: back to RX, then guard, then deferred band 110
      step(); t = cyc; ptt_in = 1'b1;
      push(3'b101, 1'b1, 1'b0, 1'b1, t + LAT);
      push(3'b000, 1'b1, 1'b1, 1'b1, t + LAT + 1);
      push(3'b110, 1'b1, 1'b0, 1'b1, t + LAT + 1 + GRD);
      idle(22);
      // disable clears fault
      step(); t = cyc; sw_en = 1'b0;
      push(3'b000, 1'b1, 1'b0, 1'b0, t + LAT);
      idle(12);

      // PTT held through power-up guard never keys
      step(); ptt_in = 1'b0;
      idle(10);
      step(); t = cyc; sw_en = 1'b1;
      push(3'b000, 1'b1, 1'b1, 1'b0, t + LAT);
      push(3'b110, 1'b1, 1'b0, 1'b0, t + LAT + GRD);
      idle(20);
      // short bounce pulses on rx430 are rejected
      for (int i = 0; i < 4; i++) begin
         sw_rx430 = 1'b0;
         idle(3);
         sw_rx430 = 1'b1;
         idle(3);
      end
      idle(10);
      step(); ptt_in = 1'b1;
      idle(10);
      step(); t = cyc; ptt_in = 1'b0;
      push(3'b110, 1'b0, 1'b0, 1'b0, t + LAT);
      idle(12);
      step(); t = cyc; sw_tx430 = 1'b1;
      push(3'b110, 1'b0, 1'b0, 1'b1, t + LAT);
      idle(12);

      // asynchronous reset mid-TX
      @(posedge clk);
      #3;
      reset = 1'b0;
      push(3'b000, 1'b1, 1'b0, 1'b0, cyc);
      #1;
      checks++;
      if (ptt !== 1'b1) begin errors++; $display("FAIL async_rst_ptt: got %b, expected 1", ptt); end
      checks++;
      if (band !== 3'b000) begin errors++; $display("FAIL async_rst_band: got %b, expected 000", band); end
      checks++;
      if (fault !== 1'b0) begin errors++; $display("FAIL async_rst_fault: got %b, expected 0", fault); end
      idle(3);

      // after release en must debounce again; held PTT does not key
      step(); t = cyc; reset = 1'b1;
      push(3'b000, 1'b1, 1'b1, 1'b0, t + LAT);
      push(3'b101, 1'b1, 1'b0, 1'b0, t + LAT + GRD);
      idle(24);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL pending_events: %0d expected changes never seen, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/band_ctrl.md
BAND_CTRL -- requirements
Module: band_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 16, consecutive equal synchronized samples needed to accept a new input level.
REQ-002 Parameter GUARD_CYCLES, default 64, cycles band is held at 000 before a new band code is applied; legal range 2..2^CNT_W-1.
REQ-003 Parameter CNT_W, default 20, width of the debounce and guard counters.
REQ-004 clk  input  1  single system clock; all state on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 sw_en  input  1  raw front-panel enable switch, 1 = station on; asynchronous to clk.
REQ-007 sw_rx430  input  1  raw receive-band switch, 0 = 144, 1 = 430; asynchronous.
REQ-008 sw_tx430  input  1  raw transmit-band switch, 0 = 144, 1 = 430; asynchronous.
REQ-009 ptt_in  input  1  raw operator PTT, 0 = transmit; asynchronous.
REQ-010 band  output  3  registered band code to the band mux.
REQ-011 ptt  output  1  registered PTT to the sequencer, 0 = transmit.
REQ-012 busy  output  1  registered, 1 while in GUARD.
REQ-013 fault  output  1  registered sticky flag: a band switch moved while transmitting.

Function
REQ-014 Each raw input SHALL pass a 2-flop synchronizer, then a debouncer whose output changes only after DEB_CYCLES consecutive equal synchronized samples.
REQ-015 Requested code from debounced rx/tx: 0/0 -> 100, 1/1 -> 101, 1/0 -> 110, 0/1 -> 111; code 000 = all off.
REQ-016 FSM states OFF, GUARD, RX, TX; a latched target register holds the applied code.
REQ-017 OFF: band=000, ptt=1, busy=0; en=1 -> latch request into target, clear guard counter, go GUARD.
REQ-018 GUARD: band=000, ptt=1, busy=1; counter increments each cycle; en=0 -> OFF; request != target -> relatch target, restart counter; counter reaches GUARD_CYCLES-1 -> RX.
REQ-019 RX: band=target, ptt=1; priority en=0 -> OFF, then request != target -> GUARD (relatch, counter=0), then armed and ptt_db=0 -> TX.
REQ-020 Arm flag SHALL clear on entry to RX and set when ptt_db=1 is seen in RX; PTT held through GUARD never keys until released and pressed again.
REQ-021 TX: band=target, ptt=0; en=0 -> OFF (ptt=1, band=000 on the same edge); ptt_db=1 -> RX; request != target SHALL NOT change band and SHALL set fault.
REQ-022 Band change requested during TX SHALL be acted on from RX after PTT release (RX -> GUARD on the next cycle).
REQ-023 fault SHALL clear only in OFF or on reset.
REQ-024 Outputs SHALL be registered from next-state; each output changes on the same clock edge the FSM enters the state driving it.
REQ-025 Latency raw edge to ptt output SHALL be 2 sync + DEB_CYCLES + 1 cycles (±1 for debounce sample alignment).
REQ-026 band SHALL never go directly from one nonzero code to another; at least GUARD_CYCLES cycles of 000 separate any two nonzero codes.
REQ-027 Counters SHALL saturate, never wrap.

Reset
REQ-028 reset low SHALL asynchronously force OFF, band=000, ptt=1, busy=0, fault=0, target=000, arm=0, counters=0, synchronizer and debounced values to 0 except ptt path to 1.
REQ-029 Reset asserted mid-TX SHALL drive ptt=1 and band=000 without waiting for clk.
REQ-030 After reset release, en must debounce high before leaving OFF.

Verification (DEB_CYCLES=4, GUARD_CYCLES=8)
REQ-031 en=1, rx=0, tx=0 from reset -> band 000 with busy=1 for 8 cycles, then band=100, busy=0, ptt=1.
REQ-032 In RX 100, ptt_in=0 -> ptt=0 after 2+4+1 cycles; ptt_in=1 -> ptt=1 after same latency; band stays 100.
REQ-033 In TX 101, tx switch to 0 -> band stays 101, fault=1; release PTT -> ptt=1, then band 000 for 8 cycles, then 110; fault stays 1 until en=0.
REQ-034 ptt_in held 0 through GUARD -> RX with ptt=1; ptt stays 1 until ptt_in released then pressed again.
REQ-035 Switch bounce of 3-cycle pulses on rx430 -> no band or busy change.
REQ-036 reset low mid-TX -> ptt=1, band=000, fault=0 immediately, before next clk edge.
